sr_uart_tx: RTL and testbench

UART transmitter that drains the core's output FIFO. It pops a DATA_WIDTH-bit word through the FIFO read port, then serialises it on a single TX line as DATA_WIDTH/8 consecutive 8N1 frames, least-significant byte first. It sits on the read side of the core-to-host debug/console FIFO and is the consumer for the FIFO's single-cycle registered read.

---
 rtl/sr_uart_tx_if.sv | 25 ++
 rtl/sr_uart_tx.sv | 125 ++++++++++++
 tb/tb_sr_uart_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_uart_tx_if.sv
// rtl/sr_uart_tx_if.sv - FIFO read-port bundle between the core output FIFO and sr_uart_tx
//   fifoEmpty      FIFO -> UART  FIFO holds no words
//   fifoReadEnable UART -> FIFO  pop request (one word per asserted cycle)
//   fifoReadData   FIFO -> UART  registered read data, valid the cycle after the pop edge
interface sr_uart_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifoEmpty;
    logic                  fifoReadEnable;
    logic [DATA_WIDTH-1:0] fifoReadData;

    // FIFO side of the read port
    modport master (
        output fifoEmpty,
        output fifoReadData,
        input  fifoReadEnable
    );

    // Consumer (UART transmitter) side of the read port
    modport slave (
        input  fifoEmpty,
        input  fifoReadData,
        output fifoReadEnable
    );
endinterface

// File: rtl/sr_uart_tx.sv
// rtl/sr_uart_tx.sv - UART transmitter draining the output FIFO as DATA_WIDTH/8 8N1 frames per word
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   fifo   FIFO read port (sr_uart_tx_if.slave)
//   tx     registered serial line, idles high
//   busy   high whenever the FSM is not idle
module sr_uart_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 16
) (
    input  logic        clk,
    input  logic        reset,
    sr_uart_tx_if.slave fifo,
    output logic        tx,
    output logic        busy
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t                state;
    logic [DIV_W-1:0]      divCnt;
    logic [2:0]            bitCnt;
    logic [BYTE_W-1:0]     byteCnt;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic                  bitEnd;

    assign bitEnd = (divCnt == DIV_LAST);

    // Pop only from IDLE; gating with reset keeps a word from being
    // consumed while the transmitter is held in reset.
    assign fifo.fifoReadEnable = reset && (state == IDLE) && !fifo.fifoEmpty;
    assign busy                = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            divCnt   <= '0;
            bitCnt   <= '0;
            byteCnt  <= '0;
            shiftReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo.fifoReadEnable) begin
                        state <= FETCH;
                    end
                end

                // Read data is valid now, one cycle after the pop edge.
                // Driving tx low here starts the first start bit.
                FETCH: begin
                    shiftReg <= fifo.fifoReadData;
                    byteCnt  <= '0;
                    divCnt   <= '0;
                    tx       <= 1'b0;
                    state    <= START;
                end

                START: begin
                    if (bitEnd) begin
                        divCnt <= '0;
                        tx     <= shiftReg[0];
                        bitCnt <= '0;
                        state  <= DATA;
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end

                // shiftReg[0] is the bit on the line; shiftReg[1] is the next one.
                // The eighth shift leaves the next byte's LSB in shiftReg[0].
                DATA: begin
                    if (bitEnd) begin
                        divCnt   <= '0;
                        shiftReg <= {1'b0, shiftReg[DATA_WIDTH-1:1]};
                        if (bitCnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx     <= shiftReg[1];
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end

                // Bytes of one word run back to back: the next start bit
                // follows the stop bit with no idle cell.
                STOP: begin
                    if (bitEnd) begin
                        divCnt <= '0;
                        if (byteCnt == BYTE_LAST) begin
                            state <= IDLE;
                        end else begin
                            byteCnt <= byteCnt + 1'b1;
                            tx      <= 1'b0;
                            state   <= START;
                        end
                    end else begin
                        divCnt <= divCnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sr_uart_tx.sv
// tb/tb_sr_uart_tx.sv - scoreboard testbench for sr_uart_tx (lanes with CLK_DIV 4 and 16)
module tb_sr_uart_tx;
    localparam int DW   = 32;
    localparam int NB   = DW / 8;
    localparam int DIV0 = 4;
    localparam int DIV1 = 16;

    typedef struct {
        logic [7:0] data;
        int         expGap;   // idle cells expected before this frame, -1 = don't care
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sr_uart_tx_if #(.DATA_WIDTH(DW)) fifo0 ();
    sr_uart_tx_if #(.DATA_WIDTH(DW)) fifo1 ();
    logic tx0, tx1, busy0, busy1;

    sr_uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(DIV0)) dut0 (
        .clk(clk), .reset(reset), .fifo(fifo0), .tx(tx0), .busy(busy0)
    );
    sr_uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(DIV1)) dut1 (
        .clk(clk), .reset(reset), .fifo(fifo1), .tx(tx1), .busy(busy1)
    );

    logic [DW-1:0] fifoQ[2][$];
    exp_t          expQ[2][$];
    int            pushed[2];
    int            pops[2];
    int            underflow[2];
    int            enWhileBusy[2];
    int            checks = 0;
    int            passes = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic lineTx(input int ln);
        return (ln == 0) ? tx0 : tx1;
    endfunction

    function automatic logic laneBusy(input int ln);
        return (ln == 0) ? busy0 : busy1;
    endfunction

    // Ideal 8N1 line level for cell c of a frame carrying byte d.
    function automatic logic cellLevel(input logic [7:0] d, input int c);
        if (c == 0) return 1'b0;
        if (c == 9) return 1'b1;
        return d[c-1];
    endfunction

    // FIFO models: registered read, one word per readEnable cycle.
    always @(posedge clk) begin
        if (fifo0.fifoReadEnable === 1'b1) begin
            pops[0] <= pops[0] + 1;
            if (fifoQ[0].size() == 0) underflow[0] <= underflow[0] + 1;
            else fifo0.fifoReadData <= fifoQ[0].pop_front();
        end
        fifo0.fifoEmpty <= (fifoQ[0].size() == 0);
    end

    always @(posedge clk) begin
        if (fifo1.fifoReadEnable === 1'b1) begin
            pops[1] <= pops[1] + 1;
            if (fifoQ[1].size() == 0) underflow[1] <= underflow[1] + 1;
            else fifo1.fifoReadData <= fifoQ[1].pop_front();
        end
        fifo1.fifoEmpty <= (fifoQ[1].size() == 0);
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (fifo0.fifoReadEnable === 1'b1 && busy0 === 1'b1) enWhileBusy[0] <= enWhileBusy[0] + 1;
            if (fifo1.fifoReadEnable === 1'b1 && busy1 === 1'b1) enWhileBusy[1] <= enWhileBusy[1] + 1;
        end
    end

    // UART receiver monitor: captures whole frames sample-per-cycle and
    // compares against the scoreboard head.
    task automatic monitor(input int ln);
        int      div;
        int      gap;
        int      gapBefore;
        logic    s[$];
        logic [7:0] b;
        exp_t    e;
        bit      ok;
        bit      aborted;
        div = (ln == 0) ? DIV0 : DIV1;
        gap = -1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                gap = -1;
                continue;
            end
            if (lineTx(ln) !== 1'b0) begin
                if (gap >= 0) gap++;
                continue;
            end
            gapBefore = gap;
            s = {};
            s.push_back(1'b0);
            aborted = 1'b0;
            for (int i = 1; i < 10 * div; i++) begin
                @(negedge clk);
                if (reset !== 1'b1) begin
                    aborted = 1'b1;
                    break;
                end
                s.push_back(lineTx(ln));
            end
            if (aborted) begin
                gap = -1;
                continue;
            end
            for (int k = 0; k < 8; k++) b[k] = s[(k + 1) * div + div / 2];
            gap = 0;
            if (expQ[ln].size() == 0) begin
                check($sformatf("spuriousFrame%0d", ln), {56'd0, b}, 64'hFFFF);
                continue;
            end
            e = expQ[ln].pop_front();
            check($sformatf("byte%0d", ln), {56'd0, b}, {56'd0, e.data});
            ok = 1'b1;
            for (int i = 0; i < 10 * div; i++)
                if (s[i] !== cellLevel(e.data, i / div)) ok = 1'b0;
            check($sformatf("frameShape%0d", ln), {63'd0, ok}, 64'd1);
            if (e.expGap >= 0)
                check($sformatf("interWordGap%0d", ln), 64'(gapBefore), 64'(e.expGap));
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input int ln, input logic [DW-1:0] w, input bit backToBack);
        exp_t e;
        for (int k = 0; k < NB; k++) begin
            e.data   = 8'((w >> (8 * k)) & 32'hFF);
            e.expGap = (k > 0) ? 0 : (backToBack ? 2 : -1);
            expQ[ln].push_back(e);
        end
        fifoQ[ln].push_back(w);
        pushed[ln]++;
    endtask

    task automatic drain(input int ln, input int budget);
        int n = 0;
        while ((expQ[ln].size() != 0 || fifoQ[ln].size() != 0 || laneBusy(ln) !== 1'b0) && n < budget) begin
            tick(1);
            n++;
        end
        check($sformatf("drainInBudget%0d", ln), {63'd0, n < budget}, 64'd1);
    endtask

    initial begin
        int bad;
        int n;
        int cnt;
        int p0;
        int nw;
        logic [DW-1:0] w;

        #1 reset = 1'b0;
        tick(5);
        check("resetTx", {63'd0, tx0}, 64'd1);
        check("resetBusy", {63'd0, busy0}, 64'd0);
        check("resetReadEnable", {63'd0, fifo0.fifoReadEnable}, 64'd0);
        reset = 1'b1;

        // Idle with an empty FIFO.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || fifo0.fifoReadEnable !== 1'b0) bad++;
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || fifo1.fifoReadEnable !== 1'b0) bad++;
        end
        check("idleEmptyCycles", 64'(bad), 64'd0);

        // Single word: busy lasts 1 fetch cycle plus 4 frames.
        tick(1);
        p0 = pops[0];
        pushWord(0, 32'h12345678, 1'b0);
        n = 0;
        while (busy0 !== 1'b1 && n < 20) begin tick(1); n++; end
        check("busyRise", {63'd0, busy0}, 64'd1);
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 1000) begin tick(1); cnt++; end
        check("busyLength", 64'(cnt), 64'(1 + 10 * DIV0 * NB));
        drain(0, 200);
        check("singlePops", 64'(pops[0] - p0), 64'd1);

        // Back-to-back words: second pop in the first IDLE cycle.
        p0 = pops[0];
        pushWord(0, 32'hA5A5A5A5, 1'b0);
        pushWord(0, 32'h0000FF00, 1'b1);
        drain(0, 800);
        check("backToBackPops", 64'(pops[0] - p0), 64'd2);

        // Random bursts on the fast lane.
        for (int r = 0; r < 4; r++) begin
            nw = $urandom_range(1, 3);
            for (int j = 0; j < nw; j++) pushWord(0, DW'($urandom), j > 0);
            tick($urandom_range(1, 200));
        end
        drain(0, 4000);

        // Slow lane: bit timing with CLK_DIV=16.
        pushWord(1, 32'h000000FF, 1'b0);
        pushWord(1, DW'($urandom), 1'b1);
        pushWord(1, DW'($urandom), 1'b1);
        drain(1, 3000);

        // Reset during bit 3 of byte 1.
        p0 = pops[0];
        w = DW'($urandom);
        pushWord(0, w, 1'b0);
        n = 0;
        while (tx0 !== 1'b0 && n < 20) begin tick(1); n++; end
        check("midFrameStartSeen", {63'd0, tx0}, 64'd0);
        tick(14 * DIV0 + 1);
        expQ[0].delete();
        reset = 1'b0;
        #1;
        check("resetTxImmediate", {63'd0, tx0}, 64'd1);
        check("resetBusyLow", {63'd0, busy0}, 64'd0);
        pushWord(0, DW'($urandom), 1'b0);
        tick(3);
        reset = 1'b1;
        tick(1);
        check("releaseTxHigh", {63'd0, tx0}, 64'd1);
        tick(1);
        check("releaseStartBit", {63'd0, tx0}, 64'd0);
        drain(0, 400);
        check("resetPops", 64'(pops[0] - p0), 64'd2);

        tick(2);
        check("pops0", 64'(pops[0]), 64'(pushed[0]));
        check("pops1", 64'(pops[1]), 64'(pushed[1]));
        check("underflow", 64'(underflow[0] + underflow[1]), 64'd0);
        check("readEnableWhileBusy", 64'(enWhileBusy[0] + enWhileBusy[1]), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
